puf_signature_collector: RTL

Sweep controller that sits directly upstream and downstream of the `DelayPUF` arbiter chain. It drives every challenge in turn and generates the `run` launch phase, then samples `result`. Each challenge is evaluated `REPEATS` times and majority-voted. The voted bits are assembled into a 2^`PUF_LENGTH`-bit device signature, and the number of non-unanimous (unstable) challenges is counted.

---
 rtl/puf_signature_collector_if.sv | 31 +++
 rtl/puf_signature_collector.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/puf_signature_collector_if.sv
// puf_signature_collector_if: sweep control and PUF-facing signals of the signature collector.
// Rev 1.0
`default_nettype none

interface puf_signature_collector_if #(
  parameter int PUF_LENGTH = 8
);
  localparam int SIG_W = 1 << PUF_LENGTH;

  logic                  start;
  logic                  result;
  logic [PUF_LENGTH-1:0] challenge;
  logic                  run;
  logic                  busy;
  logic                  done;
  logic                  sig_valid;
  logic [SIG_W-1:0]      signature;
  logic [PUF_LENGTH:0]   unstable_count;

  modport master (
    input  start, result,
    output challenge, run, busy, done, sig_valid, signature, unstable_count
  );

  modport slave (
    output start, result,
    input  challenge, run, busy, done, sig_valid, signature, unstable_count
  );
endinterface

`default_nettype wire

// File: rtl/puf_signature_collector.sv
// puf_signature_collector: sweeps every PUF challenge, majority-votes REPEATS samples each,
// assembles the device signature and counts unstable challenges. Rev 1.0
`default_nettype none

module puf_signature_collector #(
  parameter int PUF_LENGTH    = 8,
  parameter int SETTLE_CYCLES = 10,
  parameter int EVAL_CYCLES   = 10,
  parameter int REPEATS       = 3
) (
  input  logic clk,
  input  logic reset,
  puf_signature_collector_if.master bus
);

  localparam int SIG_W   = 1 << PUF_LENGTH;
  localparam int TMAX    = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int REP_W   = $clog2(REPEATS + 1);
  localparam int VOTE_W  = $clog2(REPEATS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    EVAL   = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                state;
  logic [TIMER_W-1:0]    timer;
  logic [REP_W-1:0]      rep;
  logic [VOTE_W-1:0]     votes;
  logic [PUF_LENGTH-1:0] challenge;
  logic                  run;
  logic                  busy;
  logic                  done;
  logic                  sig_valid;
  logic [SIG_W-1:0]      signature;
  logic [PUF_LENGTH:0]   unstable_count;

  logic last_challenge;
  logic last_repeat;
  logic voted;
  logic unanimous;

  assign last_challenge = (challenge == {PUF_LENGTH{1'b1}});
  assign last_repeat    = (rep == REP_W'(REPEATS - 1));
  assign voted          = (votes > VOTE_W'(REPEATS / 2));
  assign unanimous      = (votes == '0) || (votes == VOTE_W'(REPEATS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      timer          <= '0;
      rep            <= '0;
      votes          <= '0;
      challenge      <= '0;
      run            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sig_valid      <= 1'b0;
      signature      <= '0;
      unstable_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            challenge      <= '0;
            rep            <= '0;
            votes          <= '0;
            timer          <= '0;
            signature      <= '0;
            unstable_count <= '0;
            sig_valid      <= 1'b0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer == TIMER_W'(SETTLE_CYCLES - 1)) begin
            timer <= '0;
            run   <= 1'b1;
            state <= EVAL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EVAL: begin
          // result is sampled on the edge that also drops run
          if (timer == TIMER_W'(EVAL_CYCLES - 1)) begin
            timer <= '0;
            run   <= 1'b0;
            votes <= votes + VOTE_W'(bus.result);
            state <= SAMPLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SAMPLE: begin
          if (!last_repeat) begin
            rep   <= rep + 1'b1;
            state <= SETTLE;
          end else begin
            signature <= {voted, signature[SIG_W-1:1]};
            if (!unanimous) begin
              unstable_count <= unstable_count + 1'b1;
            end
            votes <= '0;
            rep   <= '0;
            if (last_challenge) begin
              done      <= 1'b1;
              sig_valid <= 1'b1;
              state     <= FINISH;
            end else begin
              challenge <= challenge + 1'b1;
              state     <= SETTLE;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.challenge      = challenge;
  assign bus.run            = run;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.sig_valid      = sig_valid;
  assign bus.signature      = signature;
  assign bus.unstable_count = unstable_count;

endmodule

`default_nettype wire
